// File: rtl/pe_result_deskew_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_result_deskew_collector_pkg
// Brief    : shared row type, default sizes and in-flight row helper
// Revision : 1.0
// ============================================================================
package pe_result_deskew_collector_pkg;

   localparam int ARRAY_DIMENSION   = 4;
   localparam int FLOAT_SIZE        = 32;
   localparam int RESULT_FIFO_DEPTH = 16;

   typedef struct packed {
      logic                                  last;
      logic [ARRAY_DIMENSION*FLOAT_SIZE-1:0] data;
   } Result_Row;

   // Rows that may still land in the buffer after stall_req is raised.
   function automatic int deskew_inflight(input int num_data, input int skew_degree);
      return (num_data - 1) * skew_degree + 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pe_result_deskew_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : pe_result_deskew_collector_if
// Brief    : lane input bus, aligned-row output handshake and status
// Revision : 1.0
// ============================================================================
interface pe_result_deskew_collector_if
   import pe_result_deskew_collector_pkg::*;
#(
   parameter int NUM_DATA  = ARRAY_DIMENSION,
   parameter int DATA_SIZE = FLOAT_SIZE
);

   logic [NUM_DATA-1:0]           in_lane_valid;
   logic [NUM_DATA*DATA_SIZE-1:0] in_flat_data;
   logic                          in_last;
   logic                          out_valid;
   logic                          out_ready;
   logic [NUM_DATA*DATA_SIZE-1:0] out_flat_data;
   logic                          out_last;
   logic                          stall_req;
   logic [15:0]                   row_count;
   logic                          overflow_err;
   logic                          misalign_err;

   modport master (
      output in_lane_valid, in_flat_data, in_last, out_ready,
      input  out_valid, out_flat_data, out_last, stall_req,
             row_count, overflow_err, misalign_err
   );

   modport slave (
      input  in_lane_valid, in_flat_data, in_last, out_ready,
      output out_valid, out_flat_data, out_last, stall_req,
             row_count, overflow_err, misalign_err
   );

endinterface
`default_nettype wire

// File: rtl/pe_result_deskew_collector_result_row_fifo.sv
`default_nettype none
// ============================================================================
// Module   : result_row_fifo
// Brief    : synchronous FIFO with registered head, no fall-through
// Revision : 1.0
// ============================================================================
module result_row_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 129
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic [WIDTH-1:0]   r_rd_data;

   logic               w_do_pop;
   logic               w_do_push;
   logic [c_CNT_W-1:0] w_cnt_after_pop;
   logic [c_PTR_W-1:0] w_head_ptr;

   function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
      if (p == c_PTR_W'(DEPTH - 1)) return '0;
      return p + c_PTR_W'(1);
   endfunction

   always_comb begin
      w_do_pop        = pop && (r_count != '0);
      w_do_push       = push && ((r_count != c_CNT_W'(DEPTH)) || w_do_pop);
      w_cnt_after_pop = w_do_pop ? (r_count - c_CNT_W'(1)) : r_count;
      w_head_ptr      = w_do_pop ? f_next(r_rd_ptr) : r_rd_ptr;
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
   end

   // The head register is refilled from memory, or straight from the write
   // port when the pushed row becomes the only entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_rd_data <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= f_next(r_wr_ptr);
         r_rd_ptr <= w_head_ptr;
         r_count  <= w_do_push ? (w_cnt_after_pop + c_CNT_W'(1)) : w_cnt_after_pop;
         if (w_cnt_after_pop != '0) r_rd_data <= r_mem[w_head_ptr];
         else if (w_do_push)        r_rd_data <= wr_data;
      end
   end

   assign rd_data = r_rd_data;
   assign full    = (r_count == c_CNT_W'(DEPTH));
   assign empty   = (r_count == '0);
   assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/pe_result_deskew_collector.sv
`default_nettype none
// ============================================================================
// Module   : pe_result_deskew_collector
// Brief    : realigns skewed PE lane results and buffers rows for downstream
// Revision : 1.0
// ============================================================================
module pe_result_deskew_collector
   import pe_result_deskew_collector_pkg::*;
#(
   parameter int NUM_DATA    = ARRAY_DIMENSION,
   parameter int DATA_SIZE   = FLOAT_SIZE,
   parameter int SKEW_DEGREE = 1,
   parameter int FIFO_DEPTH  = RESULT_FIFO_DEPTH
) (
   input  logic clk,
   input  logic rst,
   pe_result_deskew_collector_if.slave bus
);

   localparam int c_INFLIGHT = deskew_inflight(NUM_DATA, SKEW_DEGREE);
   localparam int c_DATA_W   = NUM_DATA * DATA_SIZE;
   localparam int c_ROW_W    = c_DATA_W + 1;
   localparam int c_LAST_LEN = (NUM_DATA - 1) * SKEW_DEGREE + 1;
   localparam int c_CNT_W    = $clog2(FIFO_DEPTH + 1);
   localparam logic [c_CNT_W-1:0] c_STALL_TH = c_CNT_W'(FIFO_DEPTH - c_INFLIGHT);

   if (FIFO_DEPTH <= c_INFLIGHT) begin : g_depth_check
      $error("pe_result_deskew_collector: FIFO_DEPTH must exceed in-flight rows");
   end

   logic [NUM_DATA-1:0] w_al_valid;
   logic [c_DATA_W-1:0] w_al_data;

   // Lane i waits for the lanes launched after it, so every lane of a row
   // reaches the last tap on the same cycle.
   for (genvar gi = 0; gi < NUM_DATA; gi++) begin : g_lane
      localparam int c_LEN = (NUM_DATA - 1 - gi) * SKEW_DEGREE + 1;
      logic [c_LEN-1:0]     r_vld;
      logic [DATA_SIZE-1:0] r_dat [c_LEN];

      always_ff @(posedge clk) begin
         if (rst) begin
            r_vld <= '0;
         end else begin
            r_vld[0] <= bus.in_lane_valid[gi];
            for (int k = 1; k < c_LEN; k++) r_vld[k] <= r_vld[k-1];
         end
      end

      always_ff @(posedge clk) begin
         r_dat[0] <= bus.in_flat_data[gi*DATA_SIZE +: DATA_SIZE];
         for (int k = 1; k < c_LEN; k++) r_dat[k] <= r_dat[k-1];
      end

      assign w_al_valid[gi]                       = r_vld[c_LEN-1];
      assign w_al_data[gi*DATA_SIZE +: DATA_SIZE] = r_dat[c_LEN-1];
   end

   logic [c_LAST_LEN-1:0] r_last_dly;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_dly <= '0;
      end else begin
         r_last_dly[0] <= bus.in_last;
         for (int k = 1; k < c_LAST_LEN; k++) r_last_dly[k] <= r_last_dly[k-1];
      end
   end

   logic               w_full;
   logic               w_empty;
   logic [c_CNT_W-1:0] w_count;
   logic [c_ROW_W-1:0] w_rd_data;
   logic               w_row_all;
   logic               w_row_mix;
   logic               w_pop;
   logic               w_push_acc;
   logic               w_ovf_hit;
   logic [c_CNT_W-1:0] w_cnt_next;

   always_comb begin
      w_row_all  = &w_al_valid;
      w_row_mix  = (|w_al_valid) && !w_row_all;
      w_pop      = !w_empty && bus.out_ready;
      w_push_acc = w_row_all && (!w_full || w_pop);
      w_ovf_hit  = w_row_all && w_full && !w_pop;
      w_cnt_next = w_count;
      if (w_push_acc && !w_pop)      w_cnt_next = w_count + c_CNT_W'(1);
      else if (!w_push_acc && w_pop) w_cnt_next = w_count - c_CNT_W'(1);
   end

   result_row_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (c_ROW_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (w_push_acc),
      .pop     (w_pop),
      .wr_data ({r_last_dly[c_LAST_LEN-1], w_al_data}),
      .rd_data (w_rd_data),
      .full    (w_full),
      .empty   (w_empty),
      .count   (w_count)
   );

   logic [15:0] r_row_count;
   logic        r_overflow_err;
   logic        r_misalign_err;
   logic        r_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_row_count    <= '0;
         r_overflow_err <= 1'b0;
         r_misalign_err <= 1'b0;
         r_stall        <= 1'b0;
      end else begin
         if (w_push_acc) r_row_count <= r_row_count + 16'd1;
         if (w_ovf_hit)  r_overflow_err <= 1'b1;
         if (w_row_mix)  r_misalign_err <= 1'b1;
         r_stall <= (w_cnt_next >= c_STALL_TH);
      end
   end

   assign bus.out_valid     = !w_empty;
   assign bus.out_flat_data = w_rd_data[c_DATA_W-1:0];
   assign bus.out_last      = w_rd_data[c_DATA_W];
   assign bus.stall_req     = r_stall;
   assign bus.row_count     = r_row_count;
   assign bus.overflow_err  = r_overflow_err;
   assign bus.misalign_err  = r_misalign_err;

endmodule
`default_nettype wire

// File: doc/pe_result_deskew_collector.md
# pe_result_deskew_collector

Receive-side counterpart of the array input skew stage. It accepts per-lane PE results that leave the systolic array staggered by `SKEW_DEGREE` cycles per lane, realigns each row, and buffers aligned rows in a small FIFO. It presents them downstream with a valid/ready handshake. Because the array cannot stall mid-row, the block raises an early `stall_req` so the issuing controller stops injecting rows before buffer space runs out.

## Interface
- `NUM_DATA`, `ARRAY_DIMENSION`, number of lanes.
- `DATA_SIZE`, `FLOAT_SIZE`, bits per lane result.
- `SKEW_DEGREE`, 1, cycles of stagger between adjacent lanes.
- `FIFO_DEPTH`, 16, aligned-row entries; must exceed `INFLIGHT`.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `in_lane_valid`  in  NUM_DATA  lane i carries a valid result this cycle.
- `in_flat_data`  in  NUM_DATA*DATA_SIZE  lane i at `[DATA_SIZE*i +: DATA_SIZE]`.
- `in_last`  in  1  qualifies lane 0 only; marks the final row of a tile.
- `out_valid`  out  1  aligned row available.
- `out_ready`  in  1  downstream accepts the row.
- `out_flat_data`  out  NUM_DATA*DATA_SIZE  aligned row, same lane packing.
- `out_last`  out  1  tile-final row.
- `stall_req`  out  1  registered; upstream must stop launching rows.
- `row_count`  out  16  rows pushed since reset; wraps.
- `overflow_err`  out  1  sticky.
- `misalign_err`  out  1  sticky.

## Operation
- `INFLIGHT` = (NUM_DATA-1)*SKEW_DEGREE + 2.
- Lane i path: {valid, data} delayed (NUM_DATA-1-i)*SKEW_DEGREE + 1 cycles. `in_last` travels with lane 0.
- A row launched with lane 0 at cycle t has all lanes present at the aligned stage at cycle t + (NUM_DATA-1)*SKEW_DEGREE + 1.
- Aligned stage decision:
  - All lane valids high: push {data, last}; increment `row_count`.
  - All lane valids low: idle.
  - Mixed: drop the row; set `misalign_err`.
- Push with FIFO full and no pop the same cycle: drop the row; set `overflow_err`; `row_count` does not increment.
- Push with FIFO full and a pop the same cycle: both happen; occupancy is unchanged.
- Pop occurs when `out_valid && out_ready`.
- `out_flat_data` and `out_last` stay stable while `out_valid && !out_ready`.
- `stall_req` next-state = (occupancy after this cycle's push/pop) >= FIFO_DEPTH - INFLIGHT.
- Error flags clear only on `rst`.
- Reset values: `out_valid`, `out_flat_data`, `out_last`, `stall_req`, `row_count`, `overflow_err`, `misalign_err` all 0.
- Reset also clears all delay-line valids and the FIFO pointers. Rows in flight at reset are discarded, with no partial row emitted after reset.

## Timing
- Latency from lane-0 input to `out_valid` with an empty FIFO: (NUM_DATA-1)*SKEW_DEGREE + 2 cycles. For NUM_DATA=4, SKEW_DEGREE=1 this is 5.
- FIFO has registered outputs and no fall-through. Push at edge k makes `out_valid` visible after edge k.
- Throughput: one row per cycle sustained when `out_ready` is held high.
- `stall_req` lag is one cycle. Headroom of `INFLIGHT` covers every row already launched when `stall_req` rises, so a compliant upstream never causes overflow.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Occupancy is tracked in a counter of width clog2(FIFO_DEPTH+1).

## Structure
- Shared package: `Result_Row` packed struct {last, data[NUM_DATA*FLOAT_SIZE]}, constant `RESULT_FIFO_DEPTH`, and a `deskew_inflight(NUM_DATA, SKEW_DEGREE)` function.
- Sub-module `result_row_fifo` (params DEPTH, WIDTH): push/pop/full/empty/count, synchronous reset, registered read data. Instantiated once.
- Per-lane delay lines are generate-loop shift registers in this module, one per lane, length from the formula above.
- Elaboration check: `FIFO_DEPTH > INFLIGHT`, else `$error`.

## Test plan
- NUM_DATA=4, SKEW=1: one row with lane i = 0x10+i, lane i at cycle 0+i, `out_ready`=1 -> `out_valid` at cycle 5, data {0x13,0x12,0x11,0x10}, `row_count`=1.
- 20 back-to-back skewed rows, `in_last` on row 19, `out_ready`=1 -> 20 consecutive outputs in order, `out_last` only on the 20th, no errors.
- `out_ready`=0 while streaming, upstream honouring `stall_req` -> `stall_req` rises at occupancy 11 (16-5); no overflow; all rows drain in order once `out_ready`=1.
- `out_ready`=0, upstream ignoring `stall_req`, 20 rows -> 16 rows stored, `overflow_err`=1, `row_count`=16; simultaneous push+pop when full keeps occupancy at 16.
- Lane 2 valid missing for one row -> that row dropped, `misalign_err`=1, neighbouring rows intact.
- Assert `rst` for one cycle with 3 rows in flight and 2 in the FIFO -> all outputs 0 next cycle; no stale row appears afterward.
